// File: rtl/gbfwei_rd_stream.sv
// Weight global-buffer read streamer: turns a (base, len) command into single-word
// SRAM reads, absorbs the 1-cycle read latency in a 2-entry FIFO and presents the
// words on a valid/ready stream with a last flag. Writes to the SRAM always win.
module gbfwei_rd_stream #(
  parameter int unsigned SRAM_DEPTH_BIT = 6,
  parameter int unsigned SRAM_WIDTH     = 28,
  parameter int unsigned LEN_BIT        = SRAM_DEPTH_BIT + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_start_i,
  input  logic [SRAM_DEPTH_BIT-1:0] cfg_base_i,
  input  logic [LEN_BIT-1:0]        cfg_len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r_o,
  output logic                      ram_read_en_o,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out_i,
  input  logic                      ram_wr_active_i,
  output logic [SRAM_WIDTH-1:0]     out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [SRAM_DEPTH_BIT-1:0] base_q, base_d;
  logic [LEN_BIT-1:0]        len_q, len_d;
  logic [LEN_BIT-1:0]        issued_q, issued_d;
  logic                      done_q, done_d;
  logic                      inflight_q, inflight_last_q;

  logic [SRAM_WIDTH-1:0]     fifo_data_q [2];
  logic                      fifo_last_q [2];
  logic                      rd_ptr_q, wr_ptr_q;
  logic [1:0]                count_q;

  logic                      pop;
  logic                      rd_en;
  logic                      last_issue;
  logic [2:0]                occ_after_pop;

  // Stream side is a direct view of the FIFO head.
  always_comb begin
    out_valid_o = (count_q != 2'd0);
    out_data_o  = fifo_data_q[rd_ptr_q];
    out_last_o  = fifo_last_q[rd_ptr_q];
    pop         = out_valid_o & out_ready_i;
  end

  // Read issue: only issue when the word is guaranteed a FIFO slot on arrival.
  always_comb begin
    occ_after_pop = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    rd_en         = (state_q == StRun) && !ram_wr_active_i && (occ_after_pop < 3'd2);
    last_issue    = rd_en && (issued_q == (len_q - LEN_BIT'(1)));
    ram_read_en_o = rd_en;
    ram_addr_r_o  = base_q + issued_q[SRAM_DEPTH_BIT-1:0];
    busy_o        = (state_q != StIdle);
    done_o        = done_q;
  end

  // Command FSM next state.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          if (cfg_len_i != '0) begin
            base_d   = cfg_base_i;
            len_d    = cfg_len_i;
            issued_d = '0;
            state_d  = StRun;
          end else begin
            // Empty command completes immediately without touching the SRAM.
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (rd_en) begin
          issued_d = issued_q + LEN_BIT'(1);
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last_o) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  // Read latency tracking and 2-entry output FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= last_issue;
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= ram_data_out_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_gbfwei_rd_stream.sv
// Directed bench for gbfwei_rd_stream with an SRAM model and read/stream scoreboards.
module tb_gbfwei_rd_stream;

  localparam int AW = 6;
  localparam int DW = 28;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic          ram_read_en;
  logic [DW-1:0] ram_data = '0;
  logic          ram_wr_active = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic [DW-1:0] mem [64];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            n_total = 0;
  int            n_pass = 0;
  int            beats = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;

  gbfwei_rd_stream dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_start_i    (cfg_start),
    .cfg_base_i     (cfg_base),
    .cfg_len_i      (cfg_len),
    .busy_o         (busy),
    .done_o         (done),
    .ram_addr_r_o   (ram_addr),
    .ram_read_en_o  (ram_read_en),
    .ram_data_out_i (ram_data),
    .ram_wr_active_i(ram_wr_active),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last)
  );

  always #5 clk = ~clk;

  // SRAM wrapper model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (ram_read_en) ram_data <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle command; push expectations only when it should be accepted.
  task automatic start_cmd(input int base, input int len, input bit accept);
    cfg_start = 1'b1;
    cfg_base  = AW'(base);
    cfg_len   = LW'(len);
    if (accept) begin
      for (int i = 0; i < len; i++) begin
        addr_q.push_back(AW'((base + i) % 64));
        exp_q.push_back({(i == len - 1), DW'((base + i) % 64)});
      end
    end
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      if (toggle) out_ready = !out_ready;
      tick();
      n++;
      got = done;
    end
    out_ready = 1'b1;
    check("done_seen", 32'(got), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Monitor: checks read addresses, stream beats and stall stability.
  always @(negedge clk) begin
    logic [DW:0]   e;
    logic [AW-1:0] a;
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stall_data));
      end
      if (ram_read_en) begin
        check("read_expected", 32'(addr_q.size() > 0), 32'd1);
        check("read_vs_write", 32'(ram_wr_active), 32'd0);
        if (addr_q.size() > 0) begin
          a = addr_q.pop_front();
          check("rd_addr", 32'(ram_addr), 32'(a));
        end
      end
      if (out_valid && out_ready) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[DW-1:0]));
          check("out_last", 32'(out_last), 32'(e[DW]));
        end
        beats <= beats + 1;
      end
      stall_q    <= out_valid && !out_ready;
      stall_data <= out_data;
    end
  end

  initial begin
    int n;
    int b0;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rd_en", 32'(ram_read_en), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // 1: base 5, len 4, full throughput
    start_cmd(5, 4, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rd_en", 32'(ram_read_en), 32'd1);
    check("t1_addr0", 32'(ram_addr), 32'd5);
    tick();
    check("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_first", 32'(out_data), 32'd5);
    wait_done(50, 1'b0, n);
    check("t1_done_lat", 32'(n), 32'd4);

    // 2: address wrap
    start_cmd(62, 4, 1'b1);
    wait_done(50, 1'b0, n);
    check("t2_done_lat", 32'(n), 32'd6);

    // 3: toggling backpressure
    start_cmd(0, 8, 1'b1);
    wait_done(200, 1'b1, n);

    // 4: write contention after the second read
    start_cmd(10, 6, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      ram_wr_active = 1'b1;
      #1;
      check("t4_blocked", 32'(ram_read_en), 32'd0);
      tick();
    end
    ram_wr_active = 1'b0;
    #1;
    check("t4_resume", 32'(ram_read_en), 32'd1);
    check("t4_resume_addr", 32'(ram_addr), 32'd12);
    wait_done(50, 1'b0, n);

    // 5: empty command, then start ignored while busy
    start_cmd(0, 0, 1'b0);
    check("t5_empty_done", 32'(done), 32'd1);
    check("t5_empty_busy", 32'(busy), 32'd0);
    check("t5_empty_rd", 32'(ram_read_en), 32'd0);
    tick();
    check("t5_empty_pulse", 32'(done), 32'd0);
    check("t5_empty_valid", 32'(out_valid), 32'd0);
    start_cmd(20, 4, 1'b1);
    start_cmd(40, 3, 1'b0);
    check("t5_still_busy", 32'(busy), 32'd1);
    wait_done(50, 1'b0, n);

    // 6: reset in the middle of a command
    b0 = beats;
    start_cmd(0, 8, 1'b1);
    n = 0;
    while (beats < b0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("t6_two_beats", 32'(beats - b0), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_rd_en", 32'(ram_read_en), 32'd0);
    check("t6_rst_addr", 32'(ram_addr), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    addr_q.delete();
    tick();
    check("t6_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    start_cmd(0, 2, 1'b1);
    wait_done(50, 1'b0, n);
    check("t6_done_lat", 32'(n), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gbfwei_rd_stream.md
Name: gbfwei_rd_stream

Overview:
- Read-side controller that sits in front of the weight global-buffer SRAM wrapper.
- Takes a (base, length) read command, issues single-word reads to the wrapper's read port, and absorbs the wrapper's 1-cycle read latency.
- Delivers words on a valid/ready stream to the PE-array weight loader, with full backpressure and a last-word flag.
- Shares the SRAM port with the weight writer: a write always wins, so this block must yield whenever a write is in progress.

Parameters:
- SRAM_DEPTH_BIT, 6, address width; buffer depth is 2^SRAM_DEPTH_BIT.
- SRAM_WIDTH, 28, word width.
- LEN_BIT, SRAM_DEPTH_BIT+1, width of the length field; the maximum length is one full buffer.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle command strobe.
- cfg_base  in  SRAM_DEPTH_BIT  first read address.
- cfg_len  in  LEN_BIT  number of words; 0 means an empty command.
- busy  out  1  high from command accept until the final word is consumed.
- done  out  1  one-cycle completion pulse.
- ram_addr_r  out  SRAM_DEPTH_BIT  read address to the wrapper.
- ram_read_en  out  1  read request to the wrapper.
- ram_data_out  in  SRAM_WIDTH  wrapper read data, valid the cycle after ram_read_en.
- ram_wr_active  in  1  wrapper write_en for the same cycle; blocks reads.
- out_data  out  SRAM_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of the command.

Behaviour:
- Reset (asynchronous, rst_n low): FSM to IDLE; busy, done, out_valid, out_last, ram_read_en all 0; ram_addr_r 0; out_data 0; FIFO count, in-flight flag and counters 0.
  - Reset mid-command aborts the command.
  - Any in-flight read data is discarded.
  - No done pulse is generated.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, cfg_start=1, cfg_len!=0: latch base and len; go to RUN; busy=1 from the next cycle.
  - IDLE, cfg_start=1, cfg_len=0: stay in IDLE; done=1 in the next cycle; no reads are issued.
  - cfg_start while busy is ignored.
  - RUN: issue reads; after the last read is issued, go to DRAIN.
  - DRAIN: when the beat with out_last is accepted (out_valid && out_ready), go to IDLE, drop busy, and pulse done for one cycle in the following cycle.
- Read issue (ram_read_en and ram_addr_r are combinational from registered state):
  - ram_read_en = RUN && !ram_wr_active && (fifo_count + inflight - pop) < 2.
  - pop = out_valid && out_ready in the current cycle.
  - ram_addr_r = base + issued_count, modulo 2^SRAM_DEPTH_BIT (wraps 63 -> 0 at default).
  - issued_count increments only on cycles where ram_read_en=1.
- Latency and capture:
  - inflight register = ram_read_en delayed by one cycle.
  - When inflight=1, ram_data_out is pushed into a 2-entry output FIFO at that cycle's edge.
  - out_data/out_valid/out_last come from the FIFO head.
  - Command accepted at edge E0: first ram_read_en in cycle E0..E1, first out_valid after E2. Start-to-first-valid latency is 2 cycles when unblocked.
  - Sustained throughput is 1 word/cycle with out_ready=1 and no writes.
- FIFO and ordering:
  - The FIFO never overflows, guaranteed by the issue condition.
  - Simultaneous push and pop keeps the count unchanged.
  - Words leave in address order with no loss or duplication under any out_ready pattern.
  - out_valid stays high and out_data stays stable until accepted.
- out_last is set on the FIFO entry whose issue index equals len-1.
- ram_wr_active=1 on any cycle suppresses ram_read_en in that cycle only; the address does not advance and reads resume on the next free cycle.

Test Plan:
1. Memory preloaded mem[i]=i; base=5, len=4, out_ready=1 -> ram_read_en high for 4 consecutive cycles (addr 5,6,7,8); out_data 5,6,7,8 on consecutive cycles; out_last with 8; done one cycle after the 8 handshake; busy falls with it.
2. Wrap: base=62, len=4 -> addresses 62,63,0,1; data 62,63,0,1; last with 1.
3. Backpressure: base=0, len=8, out_ready toggling 1,0,1,0 -> data 0..7 exactly once and in order; fifo_count+inflight never exceeds 2; out_data stable while out_valid && !out_ready.
4. Write contention: base=10, len=6, ram_wr_active=1 for 3 cycles after the 2nd read -> ram_read_en=0 in those 3 cycles; reads resume at address 12; output 10..15 intact.
5. Empty and illegal commands: cfg_len=0 -> done pulse next cycle, no ram_read_en, no out_valid; cfg_start during a busy len=4 command -> ignored, original 4 words only.
6. Reset mid-run: assert rst_n=0 after 2 words of a len=8 command -> all outputs 0 immediately; after release, base=0, len=2 -> clean output 0,1 with last and done, no stale words.
